fir_stream_engine: RTL and testbench
====================================

Name: fir_stream_engine

Overview:
- Parametrised pipelined FIR engine. Generalises the fixed-tap 8-bit filter to configurable data width, coefficient width, tap count and output scaling.
- Adds run-time loadable coefficients, address wrap-around and a selectable output saturation mode.
- Streams a block of samples from a dual-port sample memory, filters them, and writes results back to the same memory.
- Sits beside the sample memory under the top-level controller, using the same start/done/cycle_count handshake.

Parameters:
- DATA_W, 8, sample and result width, two's complement.
- COEF_W, 8, coefficient width, two's complement.
- TAPS, 8, number of filter taps (≥2).
- ADDR_W, 10, memory address width.
- SHIFT, 6, arithmetic right shift applied to the accumulator before output.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled in IDLE only.
- input_addr  in  ADDR_W  first input sample address.
- output_addr  in  ADDR_W  first result address.
- sample_count  in  ADDR_W  number of samples to process.
- coef_we  in  1  coefficient write strobe.
- coef_idx  in  $clog2(TAPS)  coefficient index.
- coef_data  in  COEF_W  coefficient value.
- mem_rd_en  out  1  read strobe.
- mem_rd_addr  out  ADDR_W  read address.
- mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en.
- mem_wr_en  out  1  write strobe.
- mem_wr_addr  out  ADDR_W  write address.
- mem_wr_data  out  DATA_W  write data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- cycle_count  out  32  number of busy cycles in the last run.
- state  out  3  FSM state encoding, for debug.

Behaviour:
- Reset (async):
  - All outputs are 0; state is IDLE.
  - Delay line, pipeline registers and all coefficients clear to 0.
  - Reset mid-run aborts immediately. No further writes occur and done is not pulsed.
- States: IDLE=0, RUN=1, FLUSH=2, DONE=3.
- IDLE:
  - start=1 with sample_count≠0 latches all three address/count inputs.
  - Clears the delay line and cycle_count, then moves to RUN. busy rises the next cycle.
  - start=1 with sample_count=0 moves directly to DONE. No memory access; cycle_count=0.
- RUN:
  - mem_rd_en=1 with mem_rd_addr = input_addr+i, for i = 0 … N-1, one read per cycle.
  - Moves to FLUSH after the N-th read.
- Pipeline, for a read issued in busy cycle i:
  - cycle i+1: data shifts into delay line x[0]; older samples move x[k] → x[k+1].
  - cycle i+2: TAPS products c[k]·x[k] are registered.
  - cycle i+3: sum → arithmetic shift >> SHIFT → width reduction; mem_wr_en=1 with mem_wr_addr = output_addr+i.
- FLUSH: lasts 3 cycles, until the last write at busy cycle N+2, then moves to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- cycle_count:
  - Increments every busy cycle and holds its value until the next accepted start.
  - Equals N+3 when done pulses, for N>0.
- Samples before input_addr are treated as 0 (zero-initialised history).
- Arithmetic:
  - Product width is DATA_W+COEF_W.
  - Accumulator width is DATA_W+COEF_W+$clog2(TAPS), so the sum never overflows.
- Addresses wrap modulo 2^ADDR_W for both read and write.
- start asserted while busy or in DONE is ignored.
- coef_we while busy or in DONE is ignored. In IDLE, the write takes effect at the next edge; coef_idx ≥ TAPS is ignored.
- Overlapping input and output regions are permitted. Reads are never delayed by writes, so the result is defined by read-before-write order within the run.

Optional Feature:
- FIR_SAT_EN defined: the shifted accumulator clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- FIR_SAT_EN undefined: the low DATA_W bits are kept (wrap).

Test Plan:
- Passthrough: c0=64, other taps 0; memory holds a sine (±64, period 40); N=100, input 0, output 512 → mem[512+i]=mem[i] for all i; done pulses with cycle_count=103.
- Moving average: all 8 coefs=8; input 40 for 100 samples → outputs 5,10,15,…,40 for i=0..7, then 40 thereafter.
- Overflow: all coefs=127, input 127, N=16 → sample 7 onward is 127 with FIR_SAT_EN, and -32 (0xE0) without it.
- Wrap and zero count: input_addr=1020, N=8 → reads 1020..1023 then 0..3 in order. sample_count=0 → done the cycle after start, no rd/wr strobes, cycle_count=0.
- Interference: start pulsed and coef_we (idx 0, value 5) at busy cycle 10 → both ignored; a rerun produces identical outputs.
- Reset mid-run: rst asserted at busy cycle 20 of N=100 → mem_wr_en falls immediately, no done pulse, all coefs read back 0 (verify with a rerun giving all-zero output); a subsequent run completes normally.

Source files
------------

// File: rtl/fir_stream_engine_if.sv
// Sample-memory bus between the FIR engine (master) and the dual-port sample memory (slave).
// Read data is expected one cycle after mem_rd_en.
interface fir_stream_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;

  modport master (
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/fir_stream_engine.sv
// Pipelined block FIR: streams samples from memory, filters with loadable taps, writes results back.
// Optional macro FIR_SAT_EN: clamp results to the DATA_W range instead of wrapping.
module fir_stream_engine #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int ADDR_W = 10,
  parameter int SHIFT  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       input_addr,
  input  logic [ADDR_W-1:0]       output_addr,
  input  logic [ADDR_W-1:0]       sample_count,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_idx,
  input  logic [COEF_W-1:0]       coef_data,
  fir_stream_engine_if.master     mem,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             cycle_count,
  output logic [2:0]              state
);
  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + IDX_W;
  localparam logic [IDX_W:0] TAPS_L = (IDX_W + 1)'(TAPS);

  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, FLUSH = 3'd2, DONE = 3'd3} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]          count_q, count_d, cnt_q, cnt_d;
  logic [31:0]                cycles_q, cycles_d;
  logic                       v1_q, v2_q, v3_q;
  logic                       accept;
  logic signed [DATA_W-1:0]   x_q [TAPS];
  logic signed [DATA_W-1:0]   x_d [TAPS];
  logic signed [COEF_W-1:0]   c_q [TAPS];
  logic signed [COEF_W-1:0]   c_d [TAPS];
  logic signed [PROD_W-1:0]   p_q [TAPS];
  logic signed [PROD_W-1:0]   p_d [TAPS];
  logic signed [ACC_W-1:0]    acc, shifted;
  logic [DATA_W-1:0]          result;

  always_comb begin
    // NOTE: every signal gets its default before any branch, so no path can infer a latch.
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    count_d   = count_q;
    cnt_d     = cnt_q;
    cycles_d  = cycles_q;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        cycles_d = '0;
        if (sample_count != '0) begin
          accept    = 1'b1;
          rd_addr_d = input_addr;
          wr_addr_d = output_addr;
          count_d   = sample_count;
          cnt_d     = '0;
          state_d   = RUN;
        end else begin
          state_d = DONE;
        end
      end
      RUN: begin
        cycles_d  = cycles_q + 32'd1;
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        if (cnt_q == count_q - ADDR_W'(1)) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      FLUSH: begin
        cycles_d = cycles_q + 32'd1;
        // The pipeline is three stages deep; the last write lands in the third flush cycle.
        if (cnt_q == ADDR_W'(2)) state_d = DONE;
        else                     cnt_d   = cnt_q + ADDR_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (v3_q) wr_addr_d = wr_addr_q + ADDR_W'(1);
  end

  // Delay line restarts from zero history on every accepted run.
  always_comb begin
    x_d = x_q;
    if (accept) begin
      for (int k = 0; k < TAPS; k++) x_d[k] = '0;
    end else if (v1_q) begin
      x_d[0] = $signed(mem.mem_rd_data);
      for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
    end
  end

  always_comb begin
    c_d = c_q;
    if (state_q == IDLE && coef_we && {1'b0, coef_idx} < TAPS_L) c_d[coef_idx] = coef_data;
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++)
      p_d[k] = $signed(PROD_W'(c_q[k])) * $signed(PROD_W'(x_q[k]));
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + $signed(ACC_W'(p_q[k]));
  end

  assign shifted = acc >>> SHIFT;

`ifdef FIR_SAT_EN
  logic fits;
  assign fits   = (&shifted[ACC_W-1:DATA_W-1]) | ~(|shifted[ACC_W-1:DATA_W-1]);
  assign result = fits ? shifted[DATA_W-1:0]
                : (shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
`else
  logic unused_hi;
  assign result    = shifted[DATA_W-1:0];
  assign unused_hi = ^shifted[ACC_W-1:DATA_W];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      count_q   <= '0;
      cnt_q     <= '0;
      cycles_q  <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      // NOTE: arrays are reset too; a run after reset must see zero taps and zero history.
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
        p_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      cycles_q  <= cycles_d;
      v1_q      <= (state_q == RUN);
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      x_q       <= x_d;
      c_q       <= c_d;
      p_q       <= p_d;
    end
  end

  assign busy            = (state_q == RUN) || (state_q == FLUSH);
  assign done            = (state_q == DONE);
  assign cycle_count     = cycles_q;
  assign state           = state_q;
  assign mem.mem_rd_en   = (state_q == RUN);
  assign mem.mem_rd_addr = rd_addr_q;
  assign mem.mem_wr_en   = v3_q;
  assign mem.mem_wr_addr = wr_addr_q;
  assign mem.mem_wr_data = result;
endmodule

// File: tb/tb_fir_stream_engine.sv
// Scoreboard bench for fir_stream_engine: expected writes are queued from a behavioural FIR model
// and popped as the engine writes to the sample memory.
module tb_fir_stream_engine;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 8;
  localparam int ADDR_W = 10;
  localparam int SHIFT  = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] input_addr = '0;
  logic [ADDR_W-1:0] output_addr = '0;
  logic [ADDR_W-1:0] sample_count = '0;
  logic              coef_we = 1'b0;
  logic [2:0]        coef_idx = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              busy, done;
  logic [31:0]       cycle_count;
  logic [2:0]        state;

  fir_stream_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fir_stream_engine #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ADDR_W(ADDR_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .input_addr(input_addr), .output_addr(output_addr), .sample_count(sample_count),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .mem(bus),
    .busy(busy), .done(done), .cycle_count(cycle_count), .state(state)
  );

  always #5 clk = ~clk;

  // Sample memory; the bench preloads it through the ld_* port so only this process writes it.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en)              mem[ld_addr] <= ld_data;
    else if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en)      bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic signed [DATA_W-1:0] img [DEPTH];
  int  cm [TAPS];
  wr_t sb [$];
  int  tests = 0;
  int  fails = 0;

  function automatic logic [DATA_W-1:0] model(input int in_a, input int i);
    int acc = 0;
    for (int k = 0; k < TAPS; k++)
      if (i - k >= 0) acc += cm[k] * int'(img[(in_a + i - k) % DEPTH]);
    acc = acc >>> SHIFT;
`ifdef FIR_SAT_EN
    if (acc > 127) acc = 127;
    else if (acc < -128) acc = -128;
`endif
    return acc[DATA_W-1:0];
  endfunction

  // All helper tasks start and end just after a falling edge.
  task automatic load(input int a, input int v);
    ld_en   = 1'b1;
    ld_addr = ADDR_W'(a);
    ld_data = DATA_W'(v);
    img[a % DEPTH] = DATA_W'(v);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic set_coef(input int idx, input int v);
    coef_we   = 1'b1;
    coef_idx  = 3'(idx);
    coef_data = COEF_W'(v);
    cm[idx]   = v;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic set_all_coefs(input int v0, input int vrest);
    set_coef(0, v0);
    for (int k = 1; k < TAPS; k++) set_coef(k, vrest);
  endtask

  task automatic run_fir(input int n, input int in_a, input int out_a,
                         input int poke_at, input int rst_at);
    int  reads = 0;
    int  exp_end;
    bit  fin = 1'b0;
    wr_t w;
    for (int i = 0; i < n; i++)
      sb.push_back('{cyc: i + 3, addr: ADDR_W'(out_a + i), data: model(in_a, i)});
    exp_end      = (n == 0) ? 0 : n + 3;
    input_addr   = ADDR_W'(in_a);
    output_addr  = ADDR_W'(out_a);
    sample_count = ADDR_W'(n);
    start        = 1'b1;
    for (int cyc = 0; cyc <= n + 10 && !fin; cyc++) begin
      @(negedge clk);
      start     = (cyc == poke_at);
      coef_we   = (cyc == poke_at);
      coef_idx  = '0;
      coef_data = COEF_W'(5);
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.mem_wr_en, done, busy, state, cycle_count} !== '0) begin
          fails++;
          $display("FAIL reset_abort wr_en=%0b done=%0b busy=%0b state=%0d cycle_count=%0d want all 0",
                   bus.mem_wr_en, done, busy, state, cycle_count);
        end
        sb.delete();
        fin = 1'b1;
      end else begin
        if (cyc == 0 && n > 0) begin
          tests++;
          if (busy !== 1'b1 || state !== 3'd1) begin
            fails++;
            $display("FAIL busy_rise busy=%0b state=%0d want busy=1 state=1", busy, state);
          end
        end
        if (bus.mem_rd_en) begin
          tests++;
          if (cyc >= n || bus.mem_rd_addr !== ADDR_W'(in_a + cyc)) begin
            fails++;
            $display("FAIL rd_addr cyc=%0d got %0d want %0d (n=%0d)",
                     cyc, bus.mem_rd_addr, ADDR_W'(in_a + cyc), n);
          end
          reads++;
        end
        if (bus.mem_wr_en) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL wr_unexpected cyc=%0d addr=%0d data=%0d", cyc, bus.mem_wr_addr, bus.mem_wr_data);
          end else begin
            w = sb.pop_front();
            if (cyc != w.cyc || bus.mem_wr_addr !== w.addr || bus.mem_wr_data !== w.data) begin
              fails++;
              $display("FAIL wr_data got cyc=%0d addr=%0d data=%0d want cyc=%0d addr=%0d data=%0d",
                       cyc, bus.mem_wr_addr, $signed(bus.mem_wr_data), w.cyc, w.addr, $signed(w.data));
            end
          end
        end
        if (done) begin
          tests++;
          if (cyc != exp_end || cycle_count !== 32'(exp_end) || busy !== 1'b0) begin
            fails++;
            $display("FAIL done got cyc=%0d cycle_count=%0d busy=%0b want cyc=%0d cycle_count=%0d busy=0",
                     cyc, cycle_count, busy, exp_end, exp_end);
          end
          fin = 1'b1;
        end
      end
    end
    start   = 1'b0;
    coef_we = 1'b0;
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL timeout got no done within %0d cycles want done at cycle %0d", n + 11, exp_end);
      sb.delete();
    end else if (rst_at < 0) begin
      tests++;
      if (sb.size() != 0 || reads != n) begin
        fails++;
        $display("FAIL completion got pending_writes=%0d reads=%0d want 0 and %0d", sb.size(), reads, n);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, cycle_count, state, bus.mem_rd_en, bus.mem_wr_en,
         bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs busy=%0b done=%0b cc=%0d state=%0d rd=%0b wr=%0b want all 0",
               busy, done, cycle_count, state, bus.mem_rd_en, bus.mem_wr_en);
    end
    rst = 1'b0;
    for (int k = 0; k < TAPS; k++) cm[k] = 0;
    @(negedge clk);
    tests++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset state=%0d busy=%0b want 0 0", state, busy);
    end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 100; i++) load(i, int'(64.0 * $sin(2.0 * 3.14159265358979 * i / 40.0)));
    set_all_coefs(64, 0);
    run_fir(100, 0, 512, -1, -1);
  endtask

  task automatic test_moving_average();
    for (int i = 100; i < 200; i++) load(i, 40);
    set_all_coefs(8, 8);
    run_fir(100, 100, 600, -1, -1);
  endtask

  task automatic test_overflow();
    for (int i = 200; i < 216; i++) load(i, 127);
    set_all_coefs(127, 127);
    run_fir(16, 200, 700, -1, -1);
  endtask

  task automatic test_wrap();
    for (int j = 0; j < 8; j++) load((1020 + j) % DEPTH, 12 * j - 40);
    set_all_coefs(64, 0);
    set_coef(1, 32);
    run_fir(8, 1020, 800, -1, -1);
  endtask

  task automatic test_zero_count();
    run_fir(0, 0, 900, -1, -1);
  endtask

  task automatic test_interference();
    set_all_coefs(16, 0);
    set_coef(1, -8);
    set_coef(2, 4);
    set_coef(3, 2);
    run_fir(40, 0, 900, 10, -1);
    run_fir(40, 0, 900, -1, -1);
  endtask

  task automatic test_reset_mid_run();
    set_all_coefs(64, 0);
    run_fir(100, 0, 512, -1, 20);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < TAPS; k++) cm[k] = 0;
    @(negedge clk);
    run_fir(100, 0, 512, -1, -1);
    set_all_coefs(64, 0);
    run_fir(100, 0, 512, -1, -1);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_moving_average();
    test_overflow();
    test_wrap();
    test_zero_count();
    test_interference();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
